// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_restoring_divider_if
// Brief    : Start/busy/done handshake and operand/result bus for the
//            sequential restoring divider.
// Revision : 1.0
// ============================================================================
interface seq_restoring_divider_if;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_restoring_divider
// Brief    : 8-bit / 4-bit unsigned restoring divider, one quotient bit per
//            clock, with start/busy/done handshake and divide-by-zero flag.
// Revision : 1.0
// ============================================================================
module seq_restoring_divider (
    input  wire logic               clk,
    input  wire logic               rst,
    seq_restoring_divider_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_ZERO = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0] r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_d;
    logic [3:0] r_v;
    logic [3:0] r_r;
    logic [7:0] r_q;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_quot;
    logic [3:0] r_rem;
    logic       r_dbz;

    logic [4:0] w_t;
    logic       w_ge;
    logic [3:0] w_r_next;
    logic [7:0] w_q_next;

    // The partial remainder always stays below V, so four stored bits suffice;
    // the trial value T needs the fifth bit for the compare.
    always_comb begin
        w_t      = {r_r, r_d[r_cnt]};
        w_ge     = (w_t >= {1'b0, r_v});
        w_r_next = w_ge ? 4'(w_t - {1'b0, r_v}) : w_t[3:0];
        w_q_next = r_q;
        w_q_next[r_cnt] = w_ge;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_d     <= 8'h00;
            r_v     <= 4'h0;
            r_r     <= 4'h0;
            r_q     <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= 8'h00;
            r_rem   <= 4'h0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dbz <= 1'b0;
                        if (bus.divisor != 4'h0) begin
                            r_d     <= bus.dividend;
                            r_v     <= bus.divisor;
                            r_r     <= 4'h0;
                            r_q     <= 8'h00;
                            r_cnt   <= 3'd7;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_ZERO;
                        end
                    end
                end
                S_RUN: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd0) begin
                        r_quot  <= w_q_next;
                        r_rem   <= w_r_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                // Divide-by-zero posts its flagged result one cycle after acceptance.
                S_ZERO: begin
                    r_quot  <= 8'hFF;
                    r_rem   <= 4'h0;
                    r_dbz   <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_restoring_divider
// Brief    : Self-checking bench for seq_restoring_divider against an
//            arithmetic reference (a / b, a % b).
// Revision : 1.0
// ============================================================================
module tb_seq_restoring_divider;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [7:0] prev_q;
    logic [3:0] prev_r;
    logic       prev_z;

    seq_restoring_divider_if bus ();

    seq_restoring_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_quot"}, 32'(bus.quotient), 32'd0);
        check_eq({tag, "_rem"},  32'(bus.remainder), 32'd0);
        check_eq({tag, "_dbz"},  32'(bus.div_by_zero), 32'd0);
    endtask

    // One complete operation; samples every cycle from acceptance to IDLE.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b);
        int         lat;
        logic [7:0] eq;
        logic [3:0] er;
        logic       ez;
        lat = (b == 4'd0) ? 1 : 8;
        if (b == 4'd0) begin
            eq = 8'hFF; er = 4'h0; ez = 1'b1;
        end else begin
            eq = 8'(a / b); er = 4'(a % b); ez = 1'b0;
        end
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        for (int c = 0; c <= lat + 1; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                bus.start    = 1'b0;
                bus.dividend = 8'($urandom);
                bus.divisor  = 4'($urandom);
            end
            check_eq("busy", 32'(bus.busy), 32'((b != 4'd0) && (c < lat)));
            check_eq("done", 32'(bus.done), 32'(c == lat));
            if (c < lat) begin
                check_eq("hold_quot", 32'(bus.quotient), 32'(prev_q));
                check_eq("hold_rem", 32'(bus.remainder), 32'(prev_r));
                if (b != 4'd0)
                    check_eq("dbz_clear", 32'(bus.div_by_zero), 32'd0);
            end
            if (c == lat) begin
                check_eq("quot", 32'(bus.quotient), 32'(eq));
                check_eq("rem", 32'(bus.remainder), 32'(er));
                check_eq("dbz", 32'(bus.div_by_zero), 32'(ez));
                if (!ez) begin
                    check_eq("roundtrip", 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
                    check_eq("rem_lt_div", 32'(bus.remainder < b), 32'd1);
                end
            end
        end
        prev_q = eq;
        prev_r = er;
        prev_z = ez;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prev_q   = 8'h00;
        prev_r   = 4'h0;
        prev_z   = 1'b0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = 8'h00;
        bus.divisor  = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;

        run_div(8'd200, 4'd13);
        run_div(8'd255, 4'd1);
        run_div(8'd7,   4'd9);
        run_div(8'd225, 4'd15);
        run_div(8'd0,   4'd5);
        run_div(8'd100, 4'd0);
        run_div(8'd100, 4'd3);

        // start held high: re-accepted every 10 cycles, operands scrambled mid-run
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd7;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            check_eq("hold_busy", 32'(bus.busy), 32'((c % 10) < 8));
            check_eq("hold_done", 32'(bus.done), 32'((c % 10) == 8));
            if ((c % 10) == 8) begin
                check_eq("hold_q", 32'(bus.quotient), 32'd7);
                check_eq("hold_r", 32'(bus.remainder), 32'd1);
            end
            if ((c % 10) >= 1 && (c % 10) <= 5) begin
                bus.dividend = 8'($urandom);
                bus.divisor  = 4'($urandom);
            end
            if ((c % 10) == 6) begin
                bus.dividend = 8'd50; bus.divisor = 4'd7;
            end
            if (c == 29) bus.start = 1'b0;
        end
        prev_q = 8'd7; prev_r = 4'd1; prev_z = 1'b0;

        // reset mid-run aborts without a done pulse
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd13;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_zero("midrst");
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            check_eq("midrst_nodone", 32'(bus.done), 32'd0);
            check_eq("midrst_nobusy", 32'(bus.busy), 32'd0);
        end
        prev_q = 8'h00; prev_r = 4'h0; prev_z = 1'b0;
        run_div(8'd200, 4'd13);

        // reset and start on the same edge: start is dropped
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b1; bus.dividend = 8'd90; bus.divisor = 4'd4;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check_eq("rst_start_busy", 32'(bus.busy), 32'd0);
            check_eq("rst_start_done", 32'(bus.done), 32'd0);
        end
        prev_q = 8'h00; prev_r = 4'h0; prev_z = 1'b0;

        for (int n = 0; n < 40; n++)
            run_div(8'($urandom), 4'($urandom_range(0, 15)));

        for (int a = 0; a < 256; a++)
            for (int b = 1; b < 16; b++)
                run_div(8'(a), 4'(b));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
